// File: rtl/seven_bit_add_sequencer.sv
// seven_bit_add_sequencer: debounced nibble loader feeding a bit-serial 7-bit adder
module seven_bit_add_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PB1,
  input  logic       PB2,
  input  logic [3:0] a,
  output logic [6:0] x,
  output logic [6:0] y,
  output logic [6:0] sum,
  output logic       cout,
  output logic [2:0] state,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {S_XL, S_XH, S_YL, S_YH, S_ADD, S_DONE} state_t;
  state_t st, st_next;
  logic [1:0] raw, pulse;
  logic ld_p, clr_p, wipe, c, c_next, s_bit;
  logic [2:0] i;
  logic [7:0] xe, ye;
  assign raw = {PB2, PB1};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic s1, s2, level, p, settle;
    logic [15:0] cnt;
    assign settle = (s2 != level) && (cnt == 16'(DEBOUNCE_CYCLES - 1));
    assign pulse[b] = p;
    always_ff @(posedge clk)
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        cnt <= 16'd0;
        level <= 1'b0;
        p <= 1'b0;
      end else begin
        s1 <= raw[b];
        s2 <= s1;
        cnt <= (s2 == level || settle) ? 16'd0 : cnt + 16'd1;
        level <= settle ? s2 : level;
        p <= settle & s2;
      end
  end
  assign ld_p = pulse[0];
  assign clr_p = pulse[1];
  assign state = st;
  assign busy = st == S_ADD;
  assign done = st == S_DONE;
  assign wipe = clr_p || st > S_DONE;
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  // one full-adder slice, time-shared across the seven bit positions
  always_comb begin
    s_bit = xe[i] ^ ye[i] ^ c;
    c_next = (xe[i] & ye[i]) | (xe[i] & c) | (ye[i] & c);
  end
  always_comb begin
    st_next = st;
    case (st)
      S_XL: if (ld_p) st_next = S_XH;
      S_XH: if (ld_p) st_next = S_YL;
      S_YL: if (ld_p) st_next = S_YH;
      S_YH: if (ld_p) st_next = S_ADD;
      S_ADD: if (i == 3'd6) st_next = S_DONE;
      S_DONE: if (ld_p) st_next = S_XL;
      default: st_next = S_XL;
    endcase
    if (clr_p) st_next = S_XL;
  end
  always_ff @(posedge clk) st <= !rst_n ? S_XL : st_next;
  always_ff @(posedge clk)
    if (!rst_n || wipe) begin
      x <= '0;
      y <= '0;
      sum <= '0;
      cout <= 1'b0;
      c <= 1'b0;
      i <= '0;
    end else
      case (st)
        S_XL: if (ld_p) x[3:0] <= a;
        S_XH: if (ld_p) x[6:4] <= a[2:0];
        S_YL: if (ld_p) y[3:0] <= a;
        S_YH: if (ld_p) begin
          y[6:4] <= a[2:0];
          sum <= '0;
          cout <= 1'b0;
          c <= 1'b0;
          i <= '0;
        end
        S_ADD: begin
          sum <= sum | (7'(s_bit) << i);
          c <= c_next;
          i <= i + 3'd1;
          if (i == 3'd6) cout <= c_next;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_seven_bit_add_sequencer.sv
// tb_seven_bit_add_sequencer: randomized checks of loading, serial add, debounce, clear and reset
module tb_seven_bit_add_sequencer;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, PB1 = 0, PB2 = 0, pb_f = 0, pb2_f = 0;
  logic [3:0] a = 0, a_f = 0;
  logic [6:0] x, y, sum, x_f, y_f, sum_f;
  logic cout, busy, done, cout_f, busy_f, done_f;
  logic [2:0] state, state_f;
  int tests = 0, fails = 0, bcount = 0;
  logic [6:0] m_x = 0, m_y = 0, m_sum = 0;
  logic m_cout = 0;
  int m_state = 0;

  always #5 clk = ~clk;

  seven_bit_add_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .PB1(PB1), .PB2(PB2), .a(a), .x(x), .y(y), .sum(sum),
    .cout(cout), .state(state), .busy(busy), .done(done));

  seven_bit_add_sequencer #(.DEBOUNCE_CYCLES(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .PB1(pb_f), .PB2(pb2_f), .a(a_f), .x(x_f), .y(y_f), .sum(sum_f),
    .cout(cout_f), .state(state_f), .busy(busy_f), .done(done_f));

  always @(negedge clk) if (busy) bcount++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset;
    m_x = 0; m_y = 0; m_sum = 0; m_cout = 0; m_state = 0;
  endtask

  // reference: phases advance on each accepted press, result is plain unsigned addition
  task automatic model_ld(input logic [3:0] nib);
    int s;
    case (m_state)
      0: begin m_x = (m_x & 7'h70) | 7'(nib); m_state = 1; end
      1: begin m_x = (m_x & 7'h0F) | 7'((nib % 8) * 16); m_state = 2; end
      2: begin m_y = (m_y & 7'h70) | 7'(nib); m_state = 3; end
      3: begin
        m_y = (m_y & 7'h0F) | 7'((nib % 8) * 16);
        s = int'(m_x) + int'(m_y);
        m_sum = 7'(s % 128); m_cout = s >= 128; m_state = 5;
      end
      5: m_state = 0;
      default: ;
    endcase
  endtask

  task automatic press(input logic [3:0] nib);
    a = nib; PB1 = 1; tick(D + 4); PB1 = 0; tick(D + 4);
    model_ld(nib);
  endtask

  task automatic test_reset;
    rst_n = 0; PB1 = 0; PB2 = 0; tick(3); rst_n = 1; tick(1);
    model_reset();
    tests++;
    if ({state, x, y, sum, cout, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset: state=%0d x=%0d y=%0d sum=%0d cout=%0d busy=%0d done=%0d, want all 0",
               state, x, y, sum, cout, busy, done);
    end
  endtask

  task automatic test_basic;
    int b0;
    press(4'd3); press(4'd0); press(4'd4);
    tests++;
    if ({state, x, y} !== {3'd3, 7'd3, 7'd4}) begin
      fails++; $display("FAIL basic_load: state=%0d x=%0d y=%0d, want 3 3 4", state, x, y);
    end
    b0 = bcount; press(4'd0);
    tests++;
    if (bcount - b0 !== 7) begin
      fails++; $display("FAIL basic_busy: busy cycles=%0d, want 7", bcount - b0);
    end
    tests++;
    if ({state, done, busy, sum, cout} !== {3'(m_state), 1'b1, 1'b0, 7'd7, 1'b0}) begin
      fails++; $display("FAIL basic_result: state=%0d done=%0d busy=%0d sum=%0d cout=%0d, want 5 1 0 7 0",
                        state, done, busy, sum, cout);
    end
  endtask

  task automatic test_add_cases;
    logic [6:0] xs[8], ys[8];
    int b0;
    xs[0] = 7'd127; ys[0] = 7'd1; xs[1] = 7'd100; ys[1] = 7'd100;
    for (int k = 2; k < 8; k++) begin xs[k] = 7'($urandom); ys[k] = 7'($urandom); end
    for (int k = 0; k < 8; k++) begin
      press(4'($urandom));
      tests++;
      if ({state, x, y, sum, cout} !== {3'(m_state), m_x, m_y, m_sum, m_cout}) begin
        fails++; $display("FAIL done_press_hold: state=%0d x=%0d y=%0d sum=%0d cout=%0d, want %0d %0d %0d %0d %0d",
                          state, x, y, sum, cout, m_state, m_x, m_y, m_sum, m_cout);
      end
      press(xs[k][3:0]); press({1'($urandom), xs[k][6:4]});
      press(ys[k][3:0]);
      b0 = bcount; press({1'($urandom), ys[k][6:4]});
      tests++;
      if ({x, y, state, done} !== {xs[k], ys[k], 3'd5, 1'b1}) begin
        fails++; $display("FAIL add_operands: x=%0d y=%0d state=%0d done=%0d, want %0d %0d 5 1",
                          x, y, state, done, xs[k], ys[k]);
      end
      tests++;
      if ({cout, sum} !== 8'(xs[k]) + 8'(ys[k]) || {cout, sum} !== {m_cout, m_sum}) begin
        fails++; $display("FAIL add_result: %0d+%0d got cout=%0d sum=%0d, want cout=%0d sum=%0d",
                          xs[k], ys[k], cout, sum, m_cout, m_sum);
      end
      tests++;
      if (bcount - b0 !== 7) begin
        fails++; $display("FAIL add_busy: busy cycles=%0d, want 7", bcount - b0);
      end
    end
  endtask

  task automatic test_glitch_and_latency;
    press(4'($urandom));
    a = 4'hA; PB1 = 1; tick(3); PB1 = 0; tick(12);
    tests++;
    if ({state, x} !== {3'd0, m_x}) begin
      fails++; $display("FAIL glitch: state=%0d x=%0d, want 0 %0d", state, x, m_x);
    end
    PB1 = 1; tick(D + 2);
    tests++;
    if (state !== 3'd0) begin
      fails++; $display("FAIL latency_early: state=%0d, want 0", state);
    end
    tick(1); model_ld(4'hA);
    tests++;
    if ({state, x} !== {3'(m_state), m_x}) begin
      fails++; $display("FAIL latency_edge: state=%0d x=%0d, want %0d %0d", state, x, m_state, m_x);
    end
    PB1 = 0; tick(12);
    tests++;
    if (state !== 3'd1) begin
      fails++; $display("FAIL single_advance: state=%0d, want 1", state);
    end
  endtask

  task automatic test_clear;
    press(4'($urandom)); press(4'($urandom));
    a = 4'h5; PB1 = 1; tick(3); PB2 = 1; tick(6);
    tests++;
    if ({state, busy} !== {3'd4, 1'b1}) begin
      fails++; $display("FAIL clear_pre: state=%0d busy=%0d, want 4 1", state, busy);
    end
    tick(1); model_reset();
    tests++;
    if ({state, x, y, sum, cout, busy} !== '0) begin
      fails++; $display("FAIL clear_abort: state=%0d x=%0d y=%0d sum=%0d cout=%0d busy=%0d, want all 0",
                        state, x, y, sum, cout, busy);
    end
    tick(4);
    tests++;
    if ({state, sum, cout, done} !== '0) begin
      fails++; $display("FAIL clear_stays: state=%0d sum=%0d cout=%0d done=%0d, want all 0",
                        state, sum, cout, done);
    end
    PB1 = 0; PB2 = 0; tick(D + 4);
    a = 4'hC; PB1 = 1; PB2 = 1; tick(D + 4);
    tests++;
    if ({state, x} !== {3'd0, 7'd0}) begin
      fails++; $display("FAIL clear_wins: state=%0d x=%0d, want 0 0", state, x);
    end
    PB1 = 0; PB2 = 0; tick(D + 4);
    tests++;
    if (state !== 3'd0) begin
      fails++; $display("FAIL release_quiet: state=%0d, want 0", state);
    end
  endtask

  task automatic test_reset_mid_add;
    press(4'($urandom)); press(4'($urandom)); press(4'($urandom));
    a = 4'h6; PB1 = 1; tick(D + 3); tick(2);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rst_pre_busy: busy=%0d, want 1", busy);
    end
    rst_n = 0; tick(1); rst_n = 1; model_reset();
    tests++;
    if ({state, x, y, sum, cout, busy, done} !== '0) begin
      fails++; $display("FAIL rst_mid_add: state=%0d x=%0d y=%0d sum=%0d cout=%0d busy=%0d done=%0d, want all 0",
                        state, x, y, sum, cout, busy, done);
    end
    tick(D + 2);
    tests++;
    if (state !== 3'd0) begin
      fails++; $display("FAIL rst_held_early: state=%0d, want 0", state);
    end
    tick(1); model_ld(4'h6);
    tests++;
    if ({state, x} !== {3'(m_state), m_x}) begin
      fails++; $display("FAIL rst_held_press: state=%0d x=%0d, want %0d %0d", state, x, m_state, m_x);
    end
    PB1 = 0; tick(D + 4);
  endtask

  task automatic press_f(input logic [3:0] nib);
    a_f = nib; pb_f = 1; tick(3); pb_f = 0; tick(3);
  endtask

  task automatic test_ignore_in_add;
    logic [6:0] xv, yv;
    int n, got;
    rst_n = 0; tick(2); rst_n = 1; tick(1);
    xv = 7'($urandom); yv = 7'($urandom);
    press_f(xv[3:0]); press_f({1'b1, xv[6:4]}); press_f(yv[3:0]);
    tests++;
    if ({state_f, x_f} !== {3'd3, xv}) begin
      fails++; $display("FAIL fast_load: state=%0d x=%0d, want 3 %0d", state_f, x_f, xv);
    end
    a_f = {1'b0, yv[6:4]}; n = 0; got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      pb_f = ~pb_f;
      @(negedge clk);
      if (busy_f) n++;
      if (done_f) got = 1;
    end
    pb_f = 0;
    tests++;
    if (got !== 1 || n !== 7) begin
      fails++; $display("FAIL fast_add_schedule: done seen=%0d busy cycles=%0d, want 1 7", got, n);
    end
    tests++;
    if ({cout_f, sum_f, y_f} !== {8'(xv) + 8'(yv), yv}) begin
      fails++; $display("FAIL fast_add_result: cout=%0d sum=%0d y=%0d, want %0d (sum) y=%0d",
                        cout_f, sum_f, y_f, 8'(xv) + 8'(yv), yv);
    end
    tick(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_add_cases();
    test_glitch_and_latency();
    test_clear();
    test_reset_mid_add();
    test_ignore_in_add();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seven_bit_add_sequencer.md
# seven_bit_add_sequencer

Button-driven sequencer that loads two 7-bit operands through one 4-bit switch bank and then adds them bit-serially. A single clean advance button steps through four nibble-load phases: x low, x high, y low, y high. The block then runs a 7-cycle ripple addition with one time-shared full-adder slice and holds the result for display. It sits between the board push-buttons and switches and the LED/seven-segment outputs, and replaces the free-running edge-triggered operand capture with a clocked, debounced and sequenced flow.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized button level must hold before it is accepted (range 1..65535; 16-bit counter).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- PB1  in  1  advance/load button; raw and asynchronous.
- PB2  in  1  clear button; raw and asynchronous.
- a  in  4  operand nibble from the switches; sampled on the accepted PB1 press.
- x  out  7  operand X register.
- y  out  7  operand Y register.
- sum  out  7  result register.
- cout  out  1  carry out of bit 6.
- state  out  3  current FSM state encoding.
- busy  out  1  high while in S_ADD.
- done  out  1  high while in S_DONE.

## Operation
- Each button has its own conditioning path:
  - 2-flop synchronizer.
  - Debouncer: a counter clears whenever the synced level equals the debounced level, otherwise increments. When it reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A 0→1 flip of the debounced level produces exactly one 1-cycle pulse (ld_p for PB1, clr_p for PB2).
  - A release must also be stable for DEBOUNCE_CYCLES before another press can register.
- FSM states: S_XL=0, S_XH=1, S_YL=2, S_YH=3, S_ADD=4, S_DONE=5. Codes 6 and 7 are illegal and go to S_XL with all registers cleared.
- S_XL, ld_p: x[3:0]←a, then S_XH.
- S_XH, ld_p: x[6:4]←a[2:0] (a[3] ignored), then S_YL.
- S_YL, ld_p: y[3:0]←a, then S_YH.
- S_YH, ld_p: y[6:4]←a[2:0], then S_ADD. On the same edge: bit index i←0, carry c←0, sum←0, cout←0.
- S_ADD, each cycle:
  - sum[i]←x[i]^y[i]^c.
  - c←(x[i]&y[i])|(x[i]&c)|(y[i]&c).
  - i←i+1.
  - When i=6: cout←carry out of bit 6, then S_DONE.
  - ld_p is ignored in this state.
- S_DONE, ld_p: go to S_XL. x, y, sum and cout hold until they are overwritten by later loads or the next S_ADD entry.
- Arithmetic: unsigned, {cout,sum} = x + y mod 256. No carry-in.
- clr_p in any state: state←S_XL; x, y, sum, cout, c and i←0.
- clr_p and ld_p on the same cycle: clear wins and the load is dropped.
- Reset (rst_n=0 at an edge), applied in any state including mid-S_ADD:
  - state=S_XL; x=y=sum=0; cout=busy=done=0.
  - Synchronizers, debounced levels and debounce counters = 0.
  - Any press in progress is discarded.
- busy=(state==S_ADD) and done=(state==S_DONE), both decoded from the state register; no extra latency.

## Timing
- Press latency: PB1 sampled high at edge E0 and held → ld_p high in the cycle after edge E0+2+DEBOUNCE_CYCLES−1. Nominally 2 cycles of synchronizer plus DEBOUNCE_CYCLES.
- A PB1 high glitch shorter than DEBOUNCE_CYCLES synced cycles produces no pulse.
- Load effect: the register written by ld_p is visible the cycle after the pulse.
- Add latency:
  - ld_p in S_YH at edge T → S_ADD from T+1.
  - sum bits 0..6 written at edges T+1..T+7.
  - S_DONE and final sum/cout visible after edge T+7.
  - busy is high for exactly 7 cycles.
- Back-to-back: a new press cannot be accepted sooner than 2×DEBOUNCE_CYCLES cycles after the previous one (release + press).
- A clear during S_ADD aborts within one cycle; no partial result is retained.

## Test plan
- Reset, then load XL=3, XH=0, YL=4, YH=0 → x=3, y=4, busy high 7 cycles, then done, sum=7, cout=0, state=5.
- Load x=127 (nibbles F,7), y=1 (nibbles 1,0) → sum=0, cout=1. Repeat with x=100, y=100 → sum=72, cout=1.
- With DEBOUNCE_CYCLES=4, PB1 high for 3 cycles, then low → state stays 0 and x unchanged. Then high for 6 cycles → exactly one advance to state 1.
- Load all four nibbles, pulse PB2 three cycles into S_ADD → state=0 and x=y=sum=cout=0 within one cycle of clr_p. A PB1 pulse coincident with clr_p does not advance.
- Drive rst_n=0 for one edge mid-S_ADD, and separately while PB1 is held high → all outputs zero and state=0. The held press registers only after a full DEBOUNCE_CYCLES once rst_n=1.
- In S_DONE, press PB1 → state=0 with sum/cout held. Press PB1 during S_ADD → ignored, add completes on schedule.
